// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - instruction memory and decode handshake bundle for inst_fetch_unit
interface inst_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_pc_next;
  logic [31:0] id_inst;

  modport master (
    output imem_req, imem_addr, id_valid, id_pc, id_pc_next, id_inst,
    input  imem_ack, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_pc, id_pc_next, id_inst,
    output imem_ack, imem_rdata, id_ready
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - fetch PC, imem req/ack FSM and prefetch FIFO; IF_PERF_EN adds perf counters
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              cpu_rst_n,
  input  logic              cpu_en,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  inst_fetch_unit_if.master bus
`ifdef IF_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_bubble_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t         state, state_next;
  logic [31:0]    fpc, fpc_next;
  logic [31:0]    fpc_pending, fpc_pending_next;
  logic [31:0]    pc_mem   [DEPTH];
  logic [31:0]    inst_mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, count_next;
  logic [31:0]    last_pc, last_inst;
  logic [31:0]    head_pc, head_inst;
  logic           empty, space, push, pop;

  assign empty = (count == '0);
  // An outstanding request already owns one FIFO slot.
  assign space = (count + CW'(state != IDLE)) < CW'(DEPTH);
  assign pop   = ~empty & bus.id_ready & cpu_en & ~redirect;
  assign push  = (state == REQ) & bus.imem_ack & ~redirect;
  assign count_next = redirect ? '0 : (count + CW'(push) - CW'(pop));

  // Next-state, fetch PC and pending-redirect target.
  always_comb begin
    state_next       = state;
    fpc_next         = fpc;
    fpc_pending_next = fpc_pending;
    case (state)
      IDLE: begin
        if (redirect) fpc_next = redirect_pc;
        if (cpu_en && space) state_next = REQ;
      end
      REQ: begin
        if (bus.imem_ack && redirect) begin
          fpc_next   = redirect_pc;
          state_next = IDLE;
        end else if (bus.imem_ack) begin
          fpc_next   = fpc + 32'd4;
          state_next = (cpu_en && (count_next < CW'(DEPTH))) ? REQ : IDLE;
        end else if (redirect) begin
          // The memory still owes us a response for the old address.
          fpc_pending_next = redirect_pc;
          state_next       = DROP;
        end
      end
      DROP: begin
        if (redirect) begin
          fpc_pending_next = redirect_pc;
        end else if (bus.imem_ack) begin
          fpc_next   = fpc_pending;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state, FIFO pointers and last-seen head.
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state       <= IDLE;
      fpc         <= RESET_PC;
      fpc_pending <= RESET_PC;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      last_pc     <= '0;
      last_inst   <= '0;
    end else begin
      state       <= state_next;
      fpc         <= fpc_next;
      fpc_pending <= fpc_pending_next;
      count       <= count_next;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      if (!empty) begin
        last_pc   <= pc_mem[rd_ptr];
        last_inst <= inst_mem[rd_ptr];
      end
    end
  end

  // FIFO storage; contents only matter while count covers the slot.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fpc;
      inst_mem[wr_ptr] <= bus.imem_rdata;
    end
  end

  assign head_pc   = empty ? last_pc   : pc_mem[rd_ptr];
  assign head_inst = empty ? last_inst : inst_mem[rd_ptr];

  assign bus.imem_req   = (state != IDLE);
  assign bus.imem_addr  = fpc;
  assign bus.id_valid   = ~empty;
  assign bus.id_pc      = head_pc;
  assign bus.id_inst    = head_inst;
  assign bus.id_pc_next = head_pc + 32'd4;

`ifdef IF_PERF_EN
  // Delivered-instruction and decode-starvation counters.
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (pop) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (cpu_en && bus.id_ready && empty) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - randomized self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;
  logic        clk = 1'b0;
  logic        cpu_rst_n;
  logic        cpu_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  int          checks = 0;
  int          failures = 0;
  int          wait_cfg = 0;
  bit          stray_ack = 1'b0;
  int          wc;
  int          cur_wait;

  inst_fetch_unit_if bus ();

`ifdef IF_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  inst_fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk),
    .cpu_rst_n(cpu_rst_n),
    .cpu_en(cpu_en),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .bus(bus)
`ifdef IF_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int pick_wait();
    return (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
  endfunction

  // Instruction memory: answers each request after cur_wait wait states.
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    wc = 0;
    cur_wait = 0;
    forever begin
      @(negedge clk);
      if (!cpu_rst_n || !bus.imem_req) begin
        bus.imem_ack = 1'b0;
        wc = 0;
        cur_wait = pick_wait();
      end else begin
        if (bus.imem_ack) begin
          wc = 0;
          cur_wait = pick_wait();
        end
        bus.imem_ack   = (wc >= cur_wait);
        bus.imem_rdata = mem_word(bus.imem_addr);
        wc++;
      end
      if (stray_ack) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    cpu_rst_n = 1'b0;
    cpu_en = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    bus.id_ready = 1'b0;
    repeat (2) @(negedge clk);
    cpu_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cpu_rst_n = 1'b0;
    cpu_en = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h100;
    bus.id_ready = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || bus.id_valid !== 1'b0)
      begin failures++; $display("FAIL reset_ctrl: req=%b addr=%h valid=%b expected 0/00000000/0", bus.imem_req, bus.imem_addr, bus.id_valid); end
    checks++;
    if (bus.id_pc !== 32'h0 || bus.id_inst !== 32'h0 || bus.id_pc_next !== 32'h4)
      begin failures++; $display("FAIL reset_head: pc=%h inst=%h pc_next=%h expected 0/0/4", bus.id_pc, bus.id_inst, bus.id_pc_next); end
`ifdef IF_PERF_EN
    checks++;
    if (perf_fetch_cnt !== 32'h0 || perf_bubble_cnt !== 32'h0)
      begin failures++; $display("FAIL reset_perf: fetch=%0d bubble=%0d expected 0/0", perf_fetch_cnt, perf_bubble_cnt); end
`endif
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp;
    wait_cfg = 0;
    apply_reset();
    cpu_en = 1'b1;
    bus.id_ready = 1'b1;
    @(negedge clk); #4;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0)
      begin failures++; $display("FAIL zw_first_req: req=%b addr=%h expected 1/00000000", bus.imem_req, bus.imem_addr); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #4;
      exp = 32'(4 * k);
      checks++;
      if (bus.id_valid !== 1'b1 || bus.id_pc !== exp || bus.id_pc_next !== exp + 32'd4 ||
          bus.id_inst !== mem_word(exp) || bus.imem_addr !== exp + 32'd4)
        begin failures++; $display("FAIL zw_stream[%0d]: valid=%b pc=%h next=%h inst=%h addr=%h expected pc=%h", k, bus.id_valid, bus.id_pc, bus.id_pc_next, bus.id_inst, bus.imem_addr, exp); end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] exp_addr;
    bit          exp_valid;
    wait_cfg = 3;
    apply_reset();
    cpu_en = 1'b1;
    bus.id_ready = 1'b1;
    for (int s = 1; s <= 13; s++) begin
      @(negedge clk); #4;
      exp_addr  = 32'(4 * ((s - 1) / 4));
      exp_valid = (s % 4 == 1) && (s > 1);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_addr || bus.id_valid !== exp_valid)
        begin failures++; $display("FAIL ws_cycle[%0d]: req=%b addr=%h valid=%b expected 1/%h/%b", s, bus.imem_req, bus.imem_addr, bus.id_valid, exp_addr, exp_valid); end
      if (exp_valid) begin
        checks++;
        if (bus.id_pc !== exp_addr - 32'd4)
          begin failures++; $display("FAIL ws_pc[%0d]: pc=%h expected %h", s, bus.id_pc, exp_addr - 32'd4); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    wait_cfg = 0;
    apply_reset();
    cpu_en = 1'b1;
    bus.id_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk); #4;
      checks++;
      if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h8 || bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0)
        begin failures++; $display("FAIL bp_full[%0d]: req=%b addr=%h valid=%b pc=%h expected 0/00000008/1/00000000", s, bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_pc); end
    end
    exp = 32'h0;
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      bus.id_ready = 1'b1;
      #4;
      if (bus.id_valid) begin
        checks++;
        if (bus.id_pc !== exp || bus.id_inst !== mem_word(exp))
          begin failures++; $display("FAIL bp_order: pc=%h inst=%h expected pc=%h", bus.id_pc, bus.id_inst, exp); end
        exp += 32'd4;
      end
    end
    checks++;
    if (exp !== 32'd36)
      begin failures++; $display("FAIL bp_resume_count: next_pc=%h expected 00000024", exp); end
  endtask

  task automatic test_redirect_drop();
    bit found = 1'b0;
    wait_cfg = 3;
    apply_reset();
    cpu_en = 1'b1;
    bus.id_ready = 1'b1;
    for (int s = 0; s < 40 && !found; s++) begin
      @(negedge clk); #4;
      if (bus.imem_req && bus.imem_addr == 32'h8) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL rd_reach_8: request to 00000008 never seen"); end
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    #4;
    @(negedge clk);
    redirect = 1'b0;
    #4;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || bus.id_valid !== 1'b0)
      begin failures++; $display("FAIL rd_drop_hold: req=%b addr=%h valid=%b expected 1/00000008/0", bus.imem_req, bus.imem_addr, bus.id_valid); end
    @(negedge clk); #4;
    checks++;
    if (bus.imem_addr !== 32'h8)
      begin failures++; $display("FAIL rd_drop_ack_addr: addr=%h expected 00000008", bus.imem_addr); end
    @(negedge clk); #4;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h100 || bus.id_valid !== 1'b0)
      begin failures++; $display("FAIL rd_after_drop: req=%b addr=%h valid=%b expected 0/00000100/0", bus.imem_req, bus.imem_addr, bus.id_valid); end
    @(negedge clk); #4;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100)
      begin failures++; $display("FAIL rd_new_req: req=%b addr=%h expected 1/00000100", bus.imem_req, bus.imem_addr); end
    found = 1'b0;
    for (int s = 0; s < 12 && !found; s++) begin
      @(negedge clk); #4;
      if (bus.id_valid) found = 1'b1;
    end
    checks++;
    if (!found || bus.id_pc !== 32'h100 || bus.id_inst !== mem_word(32'h100))
      begin failures++; $display("FAIL rd_first_pc: seen=%b pc=%h inst=%h expected pc=00000100", found, bus.id_pc, bus.id_inst); end
  endtask

  task automatic test_redirect_ack();
    wait_cfg = 0;
    apply_reset();
    cpu_en = 1'b1;
    bus.id_ready = 1'b0;
    @(negedge clk); #4;
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    #4;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0)
      begin failures++; $display("FAIL ra_setup: req=%b addr=%h valid=%b pc=%h expected 1/00000004/1/00000000", bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_pc); end
    @(negedge clk);
    redirect = 1'b0;
    #4;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h40)
      begin failures++; $display("FAIL ra_flush: valid=%b req=%b addr=%h expected 0/0/00000040", bus.id_valid, bus.imem_req, bus.imem_addr); end
    @(negedge clk); #4;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40)
      begin failures++; $display("FAIL ra_new_req: req=%b addr=%h expected 1/00000040", bus.imem_req, bus.imem_addr); end
    @(negedge clk); #4;
    checks++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h40 || bus.id_inst !== mem_word(32'h40))
      begin failures++; $display("FAIL ra_first_pc: valid=%b pc=%h inst=%h expected 1/00000040", bus.id_valid, bus.id_pc, bus.id_inst); end
  endtask

  task automatic test_async_reset();
    wait_cfg = 0;
    apply_reset();
    cpu_en = 1'b1;
    bus.id_ready = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    cpu_rst_n = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || bus.id_valid !== 1'b0 ||
        bus.id_pc !== 32'h0 || bus.id_inst !== 32'h0 || bus.id_pc_next !== 32'h4)
      begin failures++; $display("FAIL ar_clear: req=%b addr=%h valid=%b pc=%h inst=%h next=%h expected 0/0/0/0/0/4", bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_pc, bus.id_inst, bus.id_pc_next); end
`ifdef IF_PERF_EN
    checks++;
    if (perf_fetch_cnt !== 32'h0 || perf_bubble_cnt !== 32'h0)
      begin failures++; $display("FAIL ar_perf: fetch=%0d bubble=%0d expected 0/0", perf_fetch_cnt, perf_bubble_cnt); end
`endif
    @(negedge clk);
    cpu_en = 1'b0;
    @(negedge clk);
    cpu_rst_n = 1'b1;
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    #4;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.id_pc !== 32'h0 || bus.imem_addr !== 32'h0)
      begin failures++; $display("FAIL ar_stray_ack: valid=%b req=%b pc=%h addr=%h expected 0/0/0/0", bus.id_valid, bus.imem_req, bus.id_pc, bus.imem_addr); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] prev_addr = 32'h0;
    bit          prev_hold = 1'b0;
    int          pops = 0;
    int          bubbles = 0;
    wait_cfg = -1;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      cpu_en = ($urandom_range(0, 9) != 0);
      bus.id_ready = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 29) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFF_FFFC);
      #4;
      if (prev_hold) begin
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr)
          begin failures++; $display("FAIL rnd_addr_stable[%0d]: req=%b addr=%h expected 1/%h", c, bus.imem_req, bus.imem_addr, prev_addr); end
      end
      prev_hold = bus.imem_req && !bus.imem_ack;
      prev_addr = bus.imem_addr;
      if (cpu_en && bus.id_ready && !bus.id_valid) bubbles++;
      if (redirect) begin
        exp_pc = redirect_pc;
      end else if (bus.id_valid && bus.id_ready && cpu_en) begin
        checks++;
        if (bus.id_pc !== exp_pc || bus.id_inst !== mem_word(exp_pc) || bus.id_pc_next !== exp_pc + 32'd4)
          begin failures++; $display("FAIL rnd_pop[%0d]: pc=%h inst=%h next=%h expected pc=%h inst=%h", c, bus.id_pc, bus.id_inst, bus.id_pc_next, exp_pc, mem_word(exp_pc)); end
        exp_pc += 32'd4;
        pops++;
      end
    end
    @(negedge clk);
    cpu_en = 1'b0;
    bus.id_ready = 1'b0;
    redirect = 1'b0;
    #4;
    checks++;
    if (pops < 100)
      begin failures++; $display("FAIL rnd_progress: pops=%0d expected at least 100", pops); end
`ifdef IF_PERF_EN
    checks++;
    if (perf_fetch_cnt !== 32'(pops) || perf_bubble_cnt !== 32'(bubbles))
      begin failures++; $display("FAIL rnd_perf: fetch=%0d bubble=%0d expected %0d/%0d", perf_fetch_cnt, perf_bubble_cnt, pops, bubbles); end
`endif
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_backpressure();
    test_redirect_drop();
    test_redirect_ack();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage for the MIPS 5-stage pipeline. It sits upstream of the decode/execute datapath. It keeps the fetch PC and runs a req/ack handshake to instruction memory, which may have variable latency. Fetched {pc, inst} pairs go into a small prefetch FIFO that the decode stage drains with a valid/ready handshake. Branch, jump and JR redirects flush the FIFO and discard any in-flight response.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- DEPTH, 2, prefetch FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  main clock; all state on rising edge.
- cpu_rst_n  input  1  reset; asynchronous, active-low.
- cpu_en  input  1  global enable; when low, no new memory request is issued and no FIFO pop occurs.
- redirect  input  1  one-cycle pulse; next fetch comes from redirect_pc.
- redirect_pc  input  32  redirect target; word aligned.
- imem_req  output  1  instruction memory request.
- imem_addr  output  32  request address; stable while imem_req=1 and not yet acked.
- imem_ack  input  1  memory completes the current request this cycle.
- imem_rdata  input  32  instruction word; valid when imem_ack=1.
- id_valid  output  1  FIFO head holds a valid instruction.
- id_ready  input  1  decode accepts the head.
- id_pc  output  32  PC of head instruction.
- id_pc_next  output  32  id_pc + 4.
- id_inst  output  32  head instruction word.

## Operation
- Fetch PC register fpc drives imem_addr.
- Space exists when count + (state≠IDLE ? 1 : 0) < DEPTH. Only one request is ever outstanding.
- Pop occurs when id_valid & id_ready & cpu_en.
- Push occurs when imem_ack=1 in REQ state, with no redirect that cycle. The pushed entry is {fpc, imem_rdata}, and fpc increments by 4 (mod 2^32; wrap from 32'hFFFF_FFFC to 0).
- FSM states IDLE, REQ, DROP. imem_req=1 in REQ and in DROP.
  - IDLE -> REQ when cpu_en & space.
  - REQ, ack, no redirect: push. Stay in REQ if space remains after push/pop and cpu_en=1; otherwise go to IDLE.
  - REQ, no ack, redirect: go to DROP. imem_addr holds the old address until ack. fpc_pending <= redirect_pc.
  - REQ, ack, redirect: no push. fpc <= redirect_pc. Go to IDLE.
  - DROP, ack: response discarded. fpc <= fpc_pending. Go to IDLE.
  - DROP, redirect: fpc_pending updated. Stay in DROP; the ack in the same cycle is still discarded.
- Redirect empties the FIFO: count <= 0, and no pop occurs that cycle. Redirect is honoured regardless of cpu_en.
- When the FIFO is empty, id_pc, id_inst and id_pc_next hold their last values. They are don't-care for consumers, but are deterministic: 0/0/4 after reset.
- Response ordering: strictly in order. Wait states are unbounded.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC.
  - id_valid=0, id_pc=0, id_inst=0, id_pc_next=4.
  - FSM=IDLE, count=0.
- imem_req rises at the first clk edge after reset release with cpu_en=1.
- Latency from ack to id_valid is one edge: the data is registered into the FIFO on the ack edge, and id_valid=1 after that edge. There is no combinational bypass.
- With zero-wait memory (ack tied high) and id_ready=1, throughput is one instruction per cycle.
- Redirect in cycle N: the FIFO is empty after edge N. In the REQ/ack case, a request to redirect_pc is issued no earlier than edge N+1.
- Simultaneous push and pop with the FIFO full is legal; count is unchanged.
- cpu_rst_n asserted mid-request: all state clears immediately. A later stray ack while in IDLE is ignored.

## Configuration
- IF_PERF_EN defined: adds two outputs, perf_fetch_cnt [31:0] and perf_bubble_cnt [31:0]. Both reset to 0 and wrap at 2^32.
  - perf_fetch_cnt increments per pop.
  - perf_bubble_cnt increments per cycle with cpu_en & id_ready & ~id_valid.
- IF_PERF_EN undefined: these ports and counters do not exist. Functional behaviour is otherwise identical.

## Test plan
- Reset release, RESET_PC=0, ack tied 1, id_ready=1: imem_addr steps 0,4,8,…. id_pc sequence 0,4,8 on consecutive cycles. id_pc_next = id_pc+4.
- Memory with 3 wait states: imem_addr stays at 0x4 for all 4 cycles of req. One instruction is delivered every 4 cycles.
- id_ready=0 with DEPTH=2: exactly 2 entries fill. imem_req then drops to 0. On id_ready=1, fetch resumes at the next sequential PC with no lost or duplicated PC.
- Redirect to 0x100 while req pending at 0x8 with ack 2 cycles later: the 0x8 data is discarded. Next imem_addr is 0x100. The first id_pc after redirect is 0x100.
- Redirect to 0x40 and ack in the same cycle: no push and the FIFO is emptied. The next request is to 0x40.
- IF_PERF_EN: 5 pops plus 3 starved cycles give perf_fetch_cnt=5 and perf_bubble_cnt=3. Asynchronous reset mid-run zeroes both counters and all outputs.
